product_display_driver: RTL and testbench
=========================================

PRODUCT_DISPLAY_DRIVER -- requirements
Module: product_display_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clock cycles each digit stays lit (1 ms at 100 MHz); legal range is 2 or more.
REQ-002 SHALL have port clk, input, 1, 100 MHz system clock; single clock domain, all state on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port product, input, 16, signed product from the upstream sequential Booth multiplier.
REQ-005 SHALL have port done, input, 1, upstream completion flag; level or pulse, only its rising edge is used.
REQ-006 SHALL have port an, output, 4, digit anodes, active-low; an[0] is the rightmost digit.
REQ-007 SHALL have port seg, output, 7, segments {g,f,e,d,c,b,a}, active-low.
REQ-008 SHALL have port dp, output, 1, decimal point, active-low.
REQ-009 SHALL have port valid, output, 1, high once a product has been captured.

Function
REQ-010 SHALL register done once and detect a rising edge as done=1 while the registered done=0.
REQ-011 SHALL load product into a 16-bit hold register on the clock edge that detects the rising edge; the load SHALL set valid=1.
REQ-012 SHALL keep the hold register unchanged while done stays high or low; only a new rising edge reloads it.
REQ-013 SHALL run a refresh counter 0..REFRESH_DIV-1 and wrap it to 0; at wrap, digit index 0..3 SHALL advance, 3 wrapping to 0.
REQ-014 SHALL register an, seg and dp; they reflect the digit index and hold register one cycle after either changes.
REQ-015 SHALL drive one anode low per cycle, for the current index, while valid=1; while valid=0, an=4'b1111 and seg=7'h7F.
REQ-016 SHALL show digit i as hex nibble hold[4i+3:4i].
REQ-017 SHALL use these seg codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-018 SHALL drive dp=0 only while index=3, valid=1 and hold[15]=1 (negative product); otherwise dp=1.
REQ-019 SHALL apply a capture first when a rising edge coincides with a digit advance; the new value is displayed from the next cycle.
REQ-020 SHALL never add a scan gap: exactly one anode is low in every cycle after valid=1.

Reset
REQ-021 SHALL, on rst=1 and without waiting for clk, clear the hold register, the registered done, the counter, the index and valid, and drive an=4'b1111, seg=7'h7F, dp=1.
REQ-022 SHALL treat done already high at reset release as no edge; the first capture needs done low then high.
REQ-023 SHALL, on reset mid-scan, abandon the scan; after release, scanning restarts at index 0, counter 0, display blank.

Configuration
REQ-024 SHALL, with macro LEADING_ZERO_BLANK_EN defined, blank (anode high for that slot) every digit above the most significant nonzero nibble; digit 0 is never blanked, and dp on digit 3 SHALL still be driven when it applies.
REQ-025 SHALL, without LEADING_ZERO_BLANK_EN, display all four digits, leading zeros included.

Verification (REFRESH_DIV=4)
REQ-026 SHALL cover reset: rst pulse mid-scan -> an=1111, seg=1111111, dp=1, valid=0 with no clock edge; blank until the next done edge.
REQ-027 SHALL cover capture: product=16'h1234, done 0->1 -> valid=1; digit 0 shows 4 (0011001); each anode low for 4 cycles, order an=1110,1101,1011,0111, repeating.
REQ-028 SHALL cover hold: done held high while product changes to 16'hFFFF -> display stays 1234; done 0->1 -> shows FFFF, dp=0 only while an=0111.
REQ-029 SHALL cover the negative product -128 x -128 = 16'h4000 and -1 x 1 = 16'hFFFF -> dp=1 for 4000, dp=0 on digit 3 for FFFF.
REQ-030 SHALL cover blanking: LEADING_ZERO_BLANK_EN defined, product=16'h0005 -> only an[0] ever low during its slot, showing 5; undefined -> 0,0,0,5 scanned.
REQ-031 SHALL cover the coincident case: rising edge on the same cycle as the counter wrap -> the new value appears on the new digit one cycle later, with no stale-digit glitch beyond that cycle.

Source files
------------

// File: rtl/product_display_driver.sv
// rtl/product_display_driver.sv - 4-digit multiplexed hex display of a captured 16-bit product.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero nibble.
module product_display_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] product,
    input  logic        done,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        valid
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic          done_q, done_d;
    logic          arm_q, arm_d;
    logic [15:0]   hold_q, hold_d;
    logic          valid_q, valid_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          rise;
    logic          wrap;
    logic          blank;
    logic [3:0]    nib;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0: seg_decode = 7'b1000000;
            4'h1: seg_decode = 7'b1111001;
            4'h2: seg_decode = 7'b0100100;
            4'h3: seg_decode = 7'b0110000;
            4'h4: seg_decode = 7'b0011001;
            4'h5: seg_decode = 7'b0010010;
            4'h6: seg_decode = 7'b0000010;
            4'h7: seg_decode = 7'b1111000;
            4'h8: seg_decode = 7'b0000000;
            4'h9: seg_decode = 7'b0010000;
            4'hA: seg_decode = 7'b0001000;
            4'hB: seg_decode = 7'b0000011;
            4'hC: seg_decode = 7'b1000110;
            4'hD: seg_decode = 7'b0100001;
            4'hE: seg_decode = 7'b0000110;
            default: seg_decode = 7'b0001110;
        endcase
    endfunction

    // arm_q stays low until done is seen low after reset, so a done already high at release is not an edge
    always_comb begin
        rise    = done & ~done_q & arm_q;
        done_d  = done;
        arm_d   = arm_q | ~done;
        hold_d  = rise ? product : hold_q;
        valid_d = valid_q | rise;
        wrap    = (cnt_q == CNT_LAST);
        cnt_d   = wrap ? '0 : cnt_q + 1'b1;
        idx_d   = wrap ? idx_q + 2'd1 : idx_q;
    end

    always_comb begin
        nib   = hold_q[{idx_q, 2'b00} +: 4];
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (hold_q[15:12] != 4'h0)     blank = 1'b0;
        else if (hold_q[11:8] != 4'h0) blank = (idx_q > 2'd2);
        else if (hold_q[7:4] != 4'h0)  blank = (idx_q > 2'd1);
        else                           blank = (idx_q > 2'd0);
`endif
        an_d  = 4'b1111;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (valid_q && !blank) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = seg_decode(nib);
        end
        if (valid_q && idx_q == 2'd3 && hold_q[15]) begin
            dp_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q  <= 1'b0;
            arm_q   <= 1'b0;
            hold_q  <= 16'h0000;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            an_q    <= 4'b1111;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            done_q  <= done_d;
            arm_q   <= arm_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign dp    = dp_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_product_display_driver.sv
// tb/tb_product_display_driver.sv - randomized scoreboard bench for product_display_driver.
`timescale 1ns/1ps
module tb_product_display_driver;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] product;
    logic        done;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        valid;

    product_display_driver #(.REFRESH_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .product(product), .done(done),
        .an(an), .seg(seg), .dp(dp), .valid(valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       valid;
    } exp_t;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    int          n;
    logic [15:0] m_hold;
    bit          m_valid;
    bit          m_prev_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Display as seen on digit `idx` given the model's captured value
    function automatic exp_t disp(input int idx);
        exp_t e;
        int   top;
        bit   blank;
        logic [15:0] h;
        logic [3:0]  nibv;
        h     = m_hold;
        nibv  = 4'((h >> (4 * idx)) & 16'hF);
        top   = 0;
        for (int k = 0; k < 4; k++) if (((h >> (4 * k)) & 16'hF) != 0) top = k;
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        blank = (idx > top);
`endif
        e.an    = 4'b1111;
        e.seg   = 7'h7F;
        e.dp    = 1'b1;
        e.valid = m_valid;
        if (m_valid && !blank) begin
            e.an  = 4'b1111 ^ 4'(1 << idx);
            e.seg = SEG_TAB[nibv];
        end
        if (m_valid && idx == 3 && h[15]) e.dp = 1'b0;
        return e;
    endfunction

    task automatic step(input logic [15:0] p, input logic d);
        exp_t e;
        product = p;
        done    = d;
        @(posedge clk);
        n++;
        e = disp(((n - 1) / DIV) % 4);
        if (d && !m_prev_done) begin
            m_hold  = p;
            m_valid = 1'b1;
        end
        m_prev_done = d;
        e.valid = m_valid;
        q.push_back(e);
        #1;
    endtask

    task automatic model_reset();
        n           = 0;
        m_hold      = 16'h0;
        m_valid     = 1'b0;
        m_prev_done = 1'b1;
        q.delete();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && q.size() > 0) begin
            e = q.pop_front();
            check("an", 32'(an), 32'(e.an));
            check("seg", 32'(seg), 32'(e.seg));
            check("dp", 32'(dp), 32'(e.dp));
            check("valid", 32'(valid), 32'(e.valid));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        product = 16'h0;
        done    = 1'b1;
        model_reset();
        #1;
        check("reset_an", 32'(an), 32'hF);
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_dp", 32'(dp), 32'h1);
        check("reset_valid", 32'(valid), 32'h0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;

        // done high across release must not capture
        repeat (6) step(16'hABCD, 1'b1);
        repeat (2) step(16'h1234, 1'b0);
        repeat (20) step(16'h1234, 1'b1);
        repeat (10) step(16'hFFFF, 1'b1);
        step(16'hFFFF, 1'b0);
        repeat (20) step(16'hFFFF, 1'b1);
        step(16'h4000, 1'b0);
        repeat (20) step(16'h4000, 1'b1);
        step(16'hFFFF, 1'b0);
        repeat (20) step(16'hFFFF, 1'b1);
        step(16'h0005, 1'b0);
        repeat (20) step(16'h0005, 1'b1);

        // rising edge landing on a counter wrap
        for (int r = 0; r < 3; r++) begin
            step(16'h0005, 1'b0);
            while (((n + 1) % DIV) != 0) step(16'h0005, 1'b0);
            step(16'(r * 16'h3A5B + 16'h8C21), 1'b1);
            repeat (10) step(16'h0000, 1'b1);
        end

        // asynchronous reset mid-scan
        repeat (5) step(16'h0000, 1'b1);
        done = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_an", 32'(an), 32'hF);
        check("midrst_seg", 32'(seg), 32'h7F);
        check("midrst_dp", 32'(dp), 32'h1);
        check("midrst_valid", 32'(valid), 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        m_prev_done = 1'b0;
        repeat (8) step(16'h7777, 1'b0);

        for (int i = 0; i < 300; i++) begin
            logic d;
            d = ($urandom_range(0, 5) == 0) ? ~m_prev_done : m_prev_done;
            step(16'($urandom), d);
        end

        @(negedge clk);
        #2;
        check("queue_drained", 32'(q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
